// File: rtl/mc_pkg.sv
// Shared definitions for the NITC-RISC24 multicycle datapath and its controller:
// control-field encodings, instruction field positions and the default word width.
package mc_pkg;

    localparam int MC_WIDTH = 16;

    // alucontrol
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_NAND  = 2'b10;
    localparam logic [1:0] ALU_PASSB = 2'b11;

    // alusrcb
    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_ONE  = 2'b01;
    localparam logic [1:0] SRCB_IMM6 = 2'b10;
    localparam logic [1:0] SRCB_IMM9 = 2'b11;

    // pcsrc
    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_B      = 2'b10;
    localparam logic [1:0] PC_HOLD   = 2'b11;

    // Instruction register field positions
    localparam int OP_MSB   = 15;
    localparam int OP_LSB   = 12;
    localparam int RA_MSB   = 11;
    localparam int RA_LSB   = 9;
    localparam int RB_MSB   = 8;
    localparam int RB_LSB   = 6;
    localparam int RC_MSB   = 5;
    localparam int RC_LSB   = 3;
    localparam int IMM6_MSB = 5;
    localparam int IMM9_MSB = 8;

endpackage

// File: rtl/mc_regfile.sv
// General-purpose register file: two asynchronous read ports, one synchronous
// write port, all entries cleared by synchronous reset. No write-to-read bypass.
module mc_regfile
    import mc_pkg::*;
#(
    parameter int NREGS = 8,
    parameter int WIDTH = MC_WIDTH,
    parameter int AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    output logic [WIDTH-1:0] rd1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] regs_reg [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_reg[i] <= '0;
            end
        end else if (we) begin
            regs_reg[wa] <= wd;
        end
    end

    assign rd1 = regs_reg[ra1];
    assign rd2 = regs_reg[ra2];

endmodule

// File: rtl/mc_datapath.sv
// Multicycle datapath for the NITC-RISC24 core: PC, IR, MDR, A, B, ALUOut,
// register file, ALU and operand/next-PC muxes, driven entirely by the controller.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int               WIDTH    = MC_WIDTH,
    parameter int               NREGS    = 8,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pcen,
    input  logic             irwrite,
    input  logic             regwrite,
    input  logic             alusrca,
    input  logic [1:0]       alusrcb,
    input  logic [1:0]       alucontrol,
    input  logic             iord,
    input  logic             memtoreg,
    input  logic             regdst,
    input  logic [1:0]       pcsrc,
    input  logic [WIDTH-1:0] readdata,
    output logic [WIDTH-1:0] adr,
    output logic [WIDTH-1:0] writedata,
    output logic [3:0]       op,
    output logic             compare
);

    localparam int RW = RA_MSB - RA_LSB + 1;

    logic [WIDTH-1:0] pc_reg, ir_reg, mdr_reg, a_reg, b_reg, aluout_reg;
    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] src_a, src_b, alu_result;
    logic [WIDTH-1:0] imm6_ext, imm9_ext;
    logic [WIDTH-1:0] rd1, rd2, rf_wd;
    logic [RW-1:0]    rf_wa;

    assign imm6_ext = {{(WIDTH-IMM6_MSB-1){ir_reg[IMM6_MSB]}}, ir_reg[IMM6_MSB:0]};
    assign imm9_ext = {{(WIDTH-IMM9_MSB-1){ir_reg[IMM9_MSB]}}, ir_reg[IMM9_MSB:0]};

    assign rf_wa = regdst ? ir_reg[RC_MSB:RC_LSB] : ir_reg[RB_MSB:RB_LSB];
    assign rf_wd = memtoreg ? mdr_reg : aluout_reg;

    mc_regfile #(
        .NREGS (NREGS),
        .WIDTH (WIDTH),
        .AW    (RW)
    ) u_regfile (
        .clk   (clk),
        .reset (reset),
        .we    (regwrite),
        .wa    (rf_wa),
        .wd    (rf_wd),
        .ra1   (ir_reg[RA_MSB:RA_LSB]),
        .rd1   (rd1),
        .ra2   (ir_reg[RB_MSB:RB_LSB]),
        .rd2   (rd2)
    );

    always_comb begin
        src_a = alusrca ? a_reg : pc_reg;
        case (alusrcb)
            SRCB_B:    src_b = b_reg;
            SRCB_ONE:  src_b = WIDTH'(1);
            SRCB_IMM6: src_b = imm6_ext;
            default:   src_b = imm9_ext;
        endcase
        // Arithmetic wraps modulo 2^WIDTH; carry and overflow are dropped.
        case (alucontrol)
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a + ~src_b + WIDTH'(1);
            ALU_NAND: alu_result = ~(src_a & src_b);
            default:  alu_result = src_b;
        endcase
    end

    always_comb begin
        case (pcsrc)
            PC_ALU:    pc_next = alu_result;
            PC_ALUOUT: pc_next = aluout_reg;
            PC_B:      pc_next = b_reg;
            default:   pc_next = pc_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg     <= RESET_PC;
            ir_reg     <= '0;
            mdr_reg    <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            aluout_reg <= '0;
        end else begin
            mdr_reg    <= readdata;
            a_reg      <= rd1;
            b_reg      <= rd2;
            aluout_reg <= alu_result;
            if (irwrite) ir_reg <= readdata;
            if (pcen)    pc_reg <= pc_next;
        end
    end

    assign adr       = iord ? aluout_reg : pc_reg;
    assign writedata = b_reg;
    assign op        = ir_reg[OP_MSB:OP_LSB];
    assign compare   = (a_reg == b_reg);

endmodule

// File: tb/tb_mc_datapath.sv
// Scoreboard bench for mc_datapath: a behavioural memory answers adr, expected
// values are queued as stimulus is applied and popped as outputs are sampled.
module tb_mc_datapath;
    import mc_pkg::*;

    logic        clk, reset, pcen, irwrite, regwrite, alusrca, iord, memtoreg, regdst;
    logic [1:0]  alusrcb, alucontrol, pcsrc;
    logic [15:0] readdata, adr, writedata;
    logic [3:0]  op;
    logic        compare;

    logic [15:0] mem [0:65535];
    assign readdata = mem[adr];

    typedef struct {
        string       name;
        logic [15:0] val;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] pc_m;
    logic [15:0] obs;

    mc_datapath dut (
        .clk        (clk),
        .reset      (reset),
        .pcen       (pcen),
        .irwrite    (irwrite),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .alucontrol (alucontrol),
        .iord       (iord),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .pcsrc      (pcsrc),
        .readdata   (readdata),
        .adr        (adr),
        .writedata  (writedata),
        .op         (op),
        .compare    (compare)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pcen = 0; irwrite = 0; regwrite = 0; alusrca = 0; alusrcb = SRCB_B;
        alucontrol = ALU_ADD; iord = 0; memtoreg = 0; regdst = 0; pcsrc = PC_HOLD;
    endtask

    task automatic push(input string n, input logic [15:0] v);
        exp_t t;
        t.name = n;
        t.val  = v;
        sb.push_back(t);
    endtask

    task automatic load_ir(input logic [15:0] instr);
        mem[pc_m] = instr;
        idle();
        irwrite = 1;
        tick();
        idle();
    endtask

    // Load MDR with val, then write it to R[r] through the IR[8:6] index.
    task automatic set_reg(input logic [2:0] r, input logic [15:0] val);
        load_ir({4'hF, 3'd0, r, 6'd0});
        mem[pc_m] = val;
        tick();
        regwrite = 1; memtoreg = 1; regdst = 0;
        tick();
        idle();
    endtask

    task automatic read_reg(input logic [2:0] r, output logic [15:0] v);
        load_ir({4'h0, 3'd0, r, 6'd0});
        tick();
        v = writedata;
    endtask

    task automatic test_reset();
        reset = 1; pcen = 1; irwrite = 1; regwrite = 1; alusrcb = SRCB_ONE; pcsrc = PC_ALU;
        mem[0] = 16'h1234;
        push("reset_adr", 16'h0000); push("reset_op", 16'h0000);
        push("reset_compare", 16'h0001); push("reset_writedata", 16'h0000);
        tick(); tick();
        obs = adr; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        obs = {12'd0, op}; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        obs = {15'd0, compare}; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        obs = writedata; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        reset = 0; idle(); pc_m = 16'h0000;
        for (int r = 0; r < 8; r++) begin
            push($sformatf("reset_r%0d", r), 16'h0000);
            read_reg(3'(r), obs);
            e = sb.pop_front(); n_cmp++;
            if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
            else $display("ok %s = %h", e.name, obs);
        end
    endtask

    task automatic test_fetch();
        mem[pc_m] = 16'h0298;
        idle();
        irwrite = 1; alusrca = 0; alusrcb = SRCB_ONE; alucontrol = ALU_ADD; pcsrc = PC_ALU; pcen = 1;
        push("fetch_pc", pc_m + 16'd1); push("fetch_op", 16'h0000);
        tick();
        idle();
        pc_m = pc_m + 16'd1;
        obs = adr; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        obs = {12'd0, op}; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
    endtask

    // R3 = R1 op R2 with R1=5, R2=7 for add, sub and nand.
    task automatic test_alu();
        logic [1:0]  ops [3]  = '{ALU_ADD, ALU_SUB, ALU_NAND};
        logic [15:0] exps [3] = '{16'd12, 16'hFFFE, 16'hFFFA};
        set_reg(3'd1, 16'd5);
        set_reg(3'd2, 16'd7);
        for (int k = 0; k < 3; k++) begin
            load_ir(16'h0298);
            push($sformatf("alu%0d_b_operand", k), 16'd7);
            tick();
            obs = writedata; e = sb.pop_front(); n_cmp++;
            if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
            else $display("ok %s = %h", e.name, obs);
            alusrca = 1; alusrcb = SRCB_B; alucontrol = ops[k];
            tick();
            regwrite = 1; regdst = 1; memtoreg = 0;
            tick();
            idle();
            push($sformatf("alu%0d_r3", k), exps[k]);
            read_reg(3'd3, obs);
            e = sb.pop_front(); n_cmp++;
            if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
            else $display("ok %s = %h", e.name, obs);
        end
    endtask

    // LW R5 <- mem[R4 + sext(6'h3E)], R4 = 0x0010, so the effective address is 0x000E.
    task automatic test_lw();
        set_reg(3'd4, 16'h0010);
        mem[16'h000E] = 16'hBEEF;
        push("lw_op", 16'h0004);
        load_ir(16'h497E);
        obs = {12'd0, op}; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        tick();
        alusrca = 1; alusrcb = SRCB_IMM6; alucontrol = ALU_ADD;
        tick();
        iord = 1;
        push("lw_adr", 16'h000E);
        #1;
        obs = adr; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        tick();
        regwrite = 1; memtoreg = 1; regdst = 0;
        tick();
        idle();
        push("lw_r5", 16'hBEEF);
        read_reg(3'd5, obs);
        e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
    endtask

    task automatic test_beq();
        set_reg(3'd1, 16'd9);
        set_reg(3'd2, 16'd9);
        load_ir(16'hC2BF);
        push("beq_eq_compare", 16'h0001); push("beq_op", 16'h000C);
        tick();
        obs = {15'd0, compare}; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        obs = {12'd0, op}; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        alusrca = 0; alusrcb = SRCB_IMM6; alucontrol = ALU_ADD; pcsrc = PC_ALU; pcen = 1;
        push("beq_target", pc_m - 16'd1);
        tick();
        idle();
        pc_m = pc_m - 16'd1;
        obs = adr; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        set_reg(3'd2, 16'd8);
        load_ir(16'hC2BF);
        push("beq_ne_compare", 16'h0000); push("beq_ne_b", 16'h0008);
        tick();
        obs = {15'd0, compare}; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        obs = writedata; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
    endtask

    // Exercise pcsrc = B, hold, ALU (with wrap) and ALUOut (positive and negative imm9).
    task automatic test_pc_sources();
        logic [15:0] ir_tab [2]  = '{16'h0080, 16'h01F0};
        logic [15:0] tgt_tab [2] = '{16'h0080, 16'hFFF0};
        set_reg(3'd2, 16'hFFFF);
        load_ir(16'h0080);
        tick();
        pcsrc = PC_B; pcen = 1;
        push("pc_from_b", 16'hFFFF);
        tick();
        idle();
        obs = adr; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        pcsrc = PC_HOLD; pcen = 1;
        push("pc_hold", 16'hFFFF);
        tick();
        idle();
        obs = adr; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        alusrca = 0; alusrcb = SRCB_ONE; alucontrol = ALU_ADD; pcsrc = PC_ALU; pcen = 1;
        push("pc_wrap", 16'h0000);
        tick();
        idle();
        pc_m = 16'h0000;
        obs = adr; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        for (int k = 0; k < 2; k++) begin
            if (k == 1) load_ir(ir_tab[k]);
            alusrcb = SRCB_IMM9; alucontrol = ALU_PASSB;
            tick();
            pcsrc = PC_ALUOUT; pcen = 1;
            push($sformatf("pc_aluout_imm9_%0d", k), tgt_tab[k]);
            tick();
            idle();
            pc_m = tgt_tab[k];
            obs = adr; e = sb.pop_front(); n_cmp++;
            if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
            else $display("ok %s = %h", e.name, obs);
        end
    endtask

    task automatic test_hazard_reset();
        set_reg(3'd1, 16'h1111);
        load_ir(16'h0248);
        mem[pc_m] = 16'h2222;
        tick();
        regwrite = 1; memtoreg = 1; regdst = 1;
        push("hazard_old", 16'h1111);
        tick();
        idle();
        obs = writedata; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        push("hazard_new", 16'h2222); push("hazard_compare", 16'h0001);
        tick();
        obs = writedata; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        obs = {15'd0, compare}; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);

        // LW interrupted by reset in its write-back cycle.
        set_reg(3'd4, 16'h0010);
        load_ir(16'h497E);
        tick();
        alusrca = 1; alusrcb = SRCB_IMM6; alucontrol = ALU_ADD;
        tick();
        iord = 1;
        tick();
        regwrite = 1; memtoreg = 1; regdst = 0; reset = 1;
        push("midreset_adr", 16'h0000); push("midreset_op", 16'h0000);
        push("midreset_writedata", 16'h0000); push("midreset_compare", 16'h0001);
        tick();
        reset = 0;
        idle();
        pc_m = 16'h0000;
        obs = adr; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        obs = {12'd0, op}; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        obs = writedata; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        obs = {15'd0, compare}; e = sb.pop_front(); n_cmp++;
        if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
        else $display("ok %s = %h", e.name, obs);
        for (int k = 0; k < 3; k++) begin
            logic [2:0] regs_tab [3] = '{3'd1, 3'd4, 3'd5};
            push($sformatf("midreset_r%0d", regs_tab[k]), 16'h0000);
            read_reg(regs_tab[k], obs);
            e = sb.pop_front(); n_cmp++;
            if (obs !== e.val) begin n_bad++; $display("FAIL %s: got %h want %h", e.name, obs, e.val); end
            else $display("ok %s = %h", e.name, obs);
        end
    endtask

    initial begin
        reset = 1;
        idle();
        pc_m = 16'h0000;
        test_reset();
        test_fetch();
        test_alu();
        test_lw();
        test_beq();
        test_pc_sources();
        test_hazard_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
